// File: rtl/fetch_decode_buffer_if.sv
// Fetch -> buffer -> decode handshake bundle, plus squash notification and status.
// master: fetch/decode/squash side; slave: the buffer itself.
interface fetch_decode_buffer_if #(
    parameter int p_seq_num_bits = 5,
    parameter int p_depth        = 4
);
    localparam int CW = $clog2(p_depth) + 1;

    logic [31:0]               f_inst;
    logic [31:0]               f_pc;
    logic [p_seq_num_bits-1:0] f_seq_num;
    logic                      f_val;
    logic                      f_rdy;

    logic [31:0]               d_inst;
    logic [31:0]               d_pc;
    logic [p_seq_num_bits-1:0] d_seq_num;
    logic                      d_val;
    logic                      d_rdy;

    logic                      squash_val;
    logic [p_seq_num_bits-1:0] squash_seq_num;

    logic [CW-1:0]             count;
    logic                      seq_err;

    modport master (
        output f_inst, f_pc, f_seq_num, f_val, d_rdy, squash_val, squash_seq_num,
        input  f_rdy, d_inst, d_pc, d_seq_num, d_val, count, seq_err
    );

    modport slave (
        input  f_inst, f_pc, f_seq_num, f_val, d_rdy, squash_val, squash_seq_num,
        output f_rdy, d_inst, d_pc, d_seq_num, d_val, count, seq_err
    );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Elastic in-order instruction queue between fetch and decode, with squash flush and
// sequence-number continuity check. Define FETCH_DECODE_BUFFER_BYPASS_EN for empty-queue bypass.
module fetch_decode_buffer #(
    parameter int p_seq_num_bits = 5,
    parameter int p_depth        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_decode_buffer_if.slave  io
);
    localparam int AW = $clog2(p_depth);
    localparam int PW = AW + 1;

    logic [31:0]               inst_mem_q [p_depth];
    logic [31:0]               pc_mem_q   [p_depth];
    logic [p_seq_num_bits-1:0] seq_mem_q  [p_depth];

    logic [PW-1:0]             rptr_q, rptr_d;
    logic [PW-1:0]             wptr_q, wptr_d;
    logic [p_seq_num_bits-1:0] exp_seq_q, exp_seq_d;
    logic                      resync_q, resync_d;
    logic                      seq_err_q, seq_err_d;

    logic empty;
    logic full;
    logic accept;
    logic deq;
    logic wr_en;

    always_comb begin
        empty  = (rptr_q == wptr_q);
        full   = (rptr_q[AW-1:0] == wptr_q[AW-1:0]) && (rptr_q[AW] != wptr_q[AW]);
        accept = io.f_val && !full && !io.squash_val;
        deq    = !empty && io.d_rdy && !io.squash_val;
`ifdef FETCH_DECODE_BUFFER_BYPASS_EN
        // An accepted message that decode takes straight off the bypass never touches storage.
        wr_en  = accept && !(empty && io.d_rdy);
`else
        wr_en  = accept;
`endif
    end

    always_comb begin
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        exp_seq_d = exp_seq_q;
        resync_d  = resync_q;
        seq_err_d = seq_err_q;
        if (io.squash_val) begin
            rptr_d   = wptr_q;
            resync_d = 1'b1;
        end else begin
            if (deq)   rptr_d = rptr_q + PW'(1);
            if (wr_en) wptr_d = wptr_q + PW'(1);
            if (accept) begin
                if (!resync_q && (io.f_seq_num != exp_seq_q)) seq_err_d = 1'b1;
                exp_seq_d = io.f_seq_num + p_seq_num_bits'(1);
                resync_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q    <= '0;
            wptr_q    <= '0;
            exp_seq_q <= '0;
            resync_q  <= 1'b1;
            seq_err_q <= 1'b0;
        end else begin
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            exp_seq_q <= exp_seq_d;
            resync_q  <= resync_d;
            seq_err_q <= seq_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem_q[wptr_q[AW-1:0]] <= io.f_inst;
            pc_mem_q[wptr_q[AW-1:0]]   <= io.f_pc;
            seq_mem_q[wptr_q[AW-1:0]]  <= io.f_seq_num;
        end
    end

    always_comb begin
        io.f_rdy   = !full;
        io.count   = wptr_q - rptr_q;
        io.seq_err = seq_err_q;
`ifdef FETCH_DECODE_BUFFER_BYPASS_EN
        if (empty) begin
            io.d_val     = io.f_val && !io.squash_val;
            io.d_inst    = io.f_inst;
            io.d_pc      = io.f_pc;
            io.d_seq_num = io.f_seq_num;
        end else begin
            io.d_val     = 1'b1;
            io.d_inst    = inst_mem_q[rptr_q[AW-1:0]];
            io.d_pc      = pc_mem_q[rptr_q[AW-1:0]];
            io.d_seq_num = seq_mem_q[rptr_q[AW-1:0]];
        end
`else
        io.d_val     = !empty;
        io.d_inst    = inst_mem_q[rptr_q[AW-1:0]];
        io.d_pc      = pc_mem_q[rptr_q[AW-1:0]];
        io.d_seq_num = seq_mem_q[rptr_q[AW-1:0]];
`endif
    end
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fetch_decode_buffer;
    localparam int SB = 5;
    localparam int D  = 4;

    typedef struct {
        logic [31:0]   inst;
        logic [31:0]   pc;
        logic [SB-1:0] seq;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_decode_buffer_if #(.p_seq_num_bits(SB), .p_depth(D)) bus ();
    fetch_decode_buffer #(.p_seq_num_bits(SB), .p_depth(D)) dut (.clk(clk), .rst(rst), .io(bus));

    ent_t          mq[$];
    bit            m_resync;
    logic [SB-1:0] m_exp;
    bit            m_err;
    bit            m_acc;
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_resync = 1'b1;
        m_exp    = '0;
        m_err    = 1'b0;
        m_acc    = 1'b0;
    endtask

    task automatic check_outputs();
        check("count",   64'(bus.count),   64'(mq.size()));
        check("f_rdy",   64'(bus.f_rdy),   64'(mq.size() < D));
        check("d_val",   64'(bus.d_val),   64'(mq.size() > 0));
        check("seq_err", 64'(bus.seq_err), 64'(m_err));
        if (mq.size() > 0) begin
            check("d_inst", 64'(bus.d_inst),    64'(mq[0].inst));
            check("d_pc",   64'(bus.d_pc),      64'(mq[0].pc));
            check("d_seq",  64'(bus.d_seq_num), 64'(mq[0].seq));
        end
    endtask

    // One clock: check state at negedge, drive inputs, then advance the model at posedge.
    task automatic cyc(input bit fv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [SB-1:0] seq, input bit dr, input bit sq,
                       input logic [SB-1:0] sqn);
        ent_t e;
        bit   deq;
        @(negedge clk);
        check_outputs();
        bus.f_val          = fv;
        bus.f_inst         = inst;
        bus.f_pc           = pc;
        bus.f_seq_num      = seq;
        bus.d_rdy          = dr;
        bus.squash_val     = sq;
        bus.squash_seq_num = sqn;
        @(posedge clk);
        m_acc = fv && (mq.size() < D) && !sq;
        deq   = (mq.size() > 0) && dr && !sq;
        if (sq) begin
            mq.delete();
            m_resync = 1'b1;
        end else begin
            if (deq) void'(mq.pop_front());
            if (m_acc) begin
                e.inst = inst; e.pc = pc; e.seq = seq;
                mq.push_back(e);
                if (!m_resync && seq != m_exp) m_err = 1'b1;
                m_exp    = SB'(seq + 1);
                m_resync = 1'b0;
            end
        end
    endtask

    task automatic idle(input bit dr);
        cyc(1'b0, '0, '0, '0, dr, 1'b0, '0);
    endtask

    task automatic send(input logic [SB-1:0] seq, input bit dr);
        cyc(1'b1, 32'h0000_0013 + 32'(seq) * 32'h100, 32'h200 + 32'(seq) * 4, seq, dr, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.f_val = 1'b0; bus.d_rdy = 1'b0; bus.squash_val = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [SB-1:0] s;
        logic [SB-1:0] sv;
        rst = 1'b0;
        bus.f_val = 1'b0; bus.f_inst = '0; bus.f_pc = '0; bus.f_seq_num = '0;
        bus.d_rdy = 1'b0; bus.squash_val = 1'b0; bus.squash_seq_num = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic in-order transfer
        cyc(1'b1, 32'h0000_0013, 32'h200, 5'd0, 1'b1, 1'b0, '0);
        cyc(1'b1, 32'h0010_0093, 32'h204, 5'd1, 1'b1, 1'b0, '0);
        idle(1'b1);
        idle(1'b1);

        // Full backpressure: offer 0..4 with d_rdy low, then drain while retrying
        do_reset();
        s = '0;
        repeat (6) begin send(s, 1'b0); if (m_acc) s++; end
        check("full_count", 64'(bus.count), 64'd4);
        check("full_frdy",  64'(bus.f_rdy), 64'd0);
        while (s < 5) begin send(s, 1'b1); if (m_acc) s++; end
        repeat (6) idle(1'b1);

        // Squash flush with a same-cycle enqueue, then resync on seq 9
        do_reset();
        send(5'd3, 1'b0); send(5'd4, 1'b0); send(5'd5, 1'b0);
        cyc(1'b1, 32'h6, 32'h6, 5'd6, 1'b0, 1'b1, 5'd2);
        send(5'd9, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Sequence wrap in the 5-bit space
        do_reset();
        send(5'd30, 1'b1); send(5'd31, 1'b1); send(5'd0, 1'b1); send(5'd1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Sequence error: seq 3 still delivered, flag sticky
        do_reset();
        send(5'd0, 1'b1); send(5'd1, 1'b1); send(5'd3, 1'b1);
        idle(1'b1);
        check("err_set", 64'(bus.seq_err), 64'd1);
        send(5'd4, 1'b1);
        idle(1'b1);

        // Async reset mid-cycle with 2 entries and the error flag raised
        do_reset();
        send(5'd0, 1'b0); send(5'd2, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("ar_count", 64'(bus.count),   64'd0);
        check("ar_dval",  64'(bus.d_val),   64'd0);
        check("ar_err",   64'(bus.seq_err), 64'd0);
        check("ar_frdy",  64'(bus.f_rdy),   64'd1);
        model_reset();
        bus.f_val = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(1'b0);

        // Random traffic
        s = 5'($urandom);
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) do_reset();
            sv = ($urandom_range(0, 24) == 0) ? SB'(s + 2) : s;
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom, sv,
                $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, SB'($urandom));
            if (m_acc) s = SB'(sv + 1);
        end
        repeat (6) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
